// File: rtl/ldpc_bp_pkg.sv
// Shared definitions for the LDPC belief-propagation datapath: default widths,
// variable-node FSM encoding and LLR saturation limits.
package ldpc_bp_pkg;

   localparam int DW_DEF = 6;
   localparam int SW_DEF = 9;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_SUM = 2'd1,
      EMIT     = 2'd2,
      DONE     = 2'd3
   } vnu_state_t;

   // Symmetric limit: the most-negative code is never produced.
   function automatic int llr_max(input int dw);
      return (1 << (dw - 1)) - 1;
   endfunction

   localparam int LLR_MAX = llr_max(DW_DEF);
   localparam int LLR_MIN = -LLR_MAX;

endpackage

// File: rtl/llr_saturate.sv
// Narrows an SW+1-bit extrinsic difference to DW-bit message width.
// VNU_SATURATE_EN defined: symmetric clip; undefined: plain wrap (truncate).
module llr_saturate
   import ldpc_bp_pkg::*;
#(
   parameter int DW = DW_DEF,
   parameter int SW = SW_DEF
) (
   input  logic signed [SW:0]   diff,
   output logic signed [DW-1:0] sat
);

`ifdef VNU_SATURATE_EN
   localparam logic signed [SW:0] MAX_V = (SW+1)'(llr_max(DW));
   localparam logic signed [SW:0] MIN_V = -MAX_V;

   always_comb begin
      sat = diff[DW-1:0];
      if (diff > MAX_V)
         sat = MAX_V[DW-1:0];
      else if (diff < MIN_V)
         sat = MIN_V[DW-1:0];
   end
`else
   logic unused_hi;

   assign unused_hi = ^diff[SW:DW];
   assign sat       = diff[DW-1:0];
`endif

endmodule

// File: rtl/variable_node_update.sv
// Variable-node update: captures the column total, makes the hard decision and
// streams one extrinsic message per edge. Clipping selected by VNU_SATURATE_EN.
module variable_node_update
   import ldpc_bp_pkg::*;
#(
   parameter int DW     = DW_DEF,
   parameter int SW     = SW_DEF,
   parameter int COL_WT = 3
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic signed [SW-1:0] col_sum,
   input  logic                 sum_valid,
   input  logic signed [DW-1:0] c2v_in,
   input  logic                 c2v_valid,
   output logic signed [DW-1:0] v2c_out,
   output logic                 v2c_valid,
   output logic                 hard_bit,
   output logic                 busy,
   output logic                 done
);

   localparam int CW = $clog2(COL_WT + 1);

   vnu_state_t           state, state_nxt;
   logic signed [SW-1:0] sum_reg;
   logic [CW-1:0]        cnt;
   logic signed [SW:0]   diff;
   logic signed [DW-1:0] diff_sat;
   logic                 capture, accept, last_edge;

   assign capture   = (state == WAIT_SUM) && sum_valid;
   assign accept    = (state == EMIT) && c2v_valid;
   assign last_edge = (cnt == CW'(COL_WT - 1));

   // One guard bit so the subtraction can never overflow before narrowing.
   assign diff = (SW+1)'(sum_reg) - (SW+1)'(c2v_in);

   llr_saturate #(.DW(DW), .SW(SW)) u_sat (
      .diff (diff),
      .sat  (diff_sat)
   );

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:     if (start)     state_nxt = WAIT_SUM;
         WAIT_SUM: if (sum_valid) state_nxt = EMIT;
         EMIT:     if (accept && last_edge) state_nxt = DONE;
         DONE:     state_nxt = IDLE;
         default:  state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         sum_reg   <= '0;
         cnt       <= '0;
         v2c_out   <= '0;
         v2c_valid <= 1'b0;
         hard_bit  <= 1'b0;
      end else begin
         state     <= state_nxt;
         v2c_valid <= accept;
         if (capture) begin
            sum_reg  <= col_sum;
            hard_bit <= col_sum[SW-1];
            cnt      <= '0;
         end
         if (accept) begin
            v2c_out <= diff_sat;
            cnt     <= cnt + 1'b1;
         end
      end
   end

   assign busy = (state != IDLE);
   assign done = (state == DONE);

endmodule

// File: tb/tb_variable_node_update.sv
// Self-checking bench for variable_node_update: directed table, protocol and
// reset sequences, plus randomized columns against an arithmetic reference.
module tb_variable_node_update;
   import ldpc_bp_pkg::*;

   localparam int DW     = 6;
   localparam int SW     = 9;
   localparam int COL_WT = 3;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic                 start = 1'b0;
   logic                 sum_valid = 1'b0;
   logic                 c2v_valid = 1'b0;
   logic signed [SW-1:0] col_sum = '0;
   logic signed [DW-1:0] c2v_in = '0;
   logic signed [DW-1:0] v2c_out;
   logic                 v2c_valid, hard_bit, busy, done;

   variable_node_update #(.DW(DW), .SW(SW), .COL_WT(COL_WT)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .col_sum   (col_sum),
      .sum_valid (sum_valid),
      .c2v_in    (c2v_in),
      .c2v_valid (c2v_valid),
      .v2c_out   (v2c_out),
      .v2c_valid (v2c_valid),
      .hard_bit  (hard_bit),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   int n_pass = 0;
   int n_total = 0;
   int q[$];
   int done_cnt = 0;
   bit done_last_ok = 1'b0;

   always @(negedge clk) begin
      if (v2c_valid) q.push_back(int'(v2c_out));
      if (done) begin
         done_cnt++;
         done_last_ok = v2c_valid;
      end
   end

   // Reference: exact integer difference, then clip or wrap to DW bits.
   function automatic int ref_v2c(input int s, input int c);
      int d, m, w;
      d = s - c;
      m = 1 << DW;
      w = ((d % m) + m) % m;
`ifdef VNU_SATURATE_EN
      w = d;
      if (d > LLR_MAX) w = LLR_MAX;
      if (d < LLR_MIN) w = LLR_MIN;
`else
      if (w >= m / 2) w = w - m;
`endif
      return w;
   endfunction

   task automatic chk(input string name, input int got, input int exp);
      n_total++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, got, exp);
   endtask

   task automatic begin_column();
      q.delete();
      done_cnt = 0;
      done_last_ok = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      #1 chk("busy_after_start", int'(busy), 1);
   endtask

   task automatic do_sum(input int s);
      sum_valid = 1'b1;
      col_sum = SW'(s);
      @(negedge clk);
      sum_valid = 1'b0;
   endtask

   task automatic do_edge(input int c);
      c2v_valid = 1'b1;
      c2v_in = DW'(c);
      @(negedge clk);
      c2v_valid = 1'b0;
   endtask

   task automatic check_column(input string name, input int e0, input int e1,
                               input int e2, input int eh);
      int exp_v[3];
      exp_v[0] = e0; exp_v[1] = e1; exp_v[2] = e2;
      idle(3);
      #1;
      chk({name, "_count"}, q.size(), COL_WT);
      for (int i = 0; i < COL_WT; i++)
         chk($sformatf("%s_v2c%0d", name, i), (i < q.size()) ? q[i] : 999, exp_v[i]);
      chk({name, "_done_pulses"}, done_cnt, 1);
      chk({name, "_done_with_last"}, int'(done_last_ok), 1);
      chk({name, "_hard_bit"}, int'(hard_bit), eh);
      chk({name, "_busy_idle"}, int'(busy), 0);
   endtask

   task automatic check_zero(input string name);
      chk({name, "_v2c_out"}, int'(v2c_out), 0);
      chk({name, "_v2c_valid"}, int'(v2c_valid), 0);
      chk({name, "_hard_bit"}, int'(hard_bit), 0);
      chk({name, "_busy"}, int'(busy), 0);
      chk({name, "_done"}, int'(done), 0);
   endtask

   typedef struct {
      int s;
      int c0, c1, c2;
      int g0, g1, g2;
      int e0, e1, e2;
      int h;
   } vec_t;

   vec_t tbl[5];

   task automatic run_vec(input string name, input vec_t v);
      begin_column();
      do_start();
      do_sum(v.s);
      idle(v.g0); do_edge(v.c0);
      idle(v.g1); do_edge(v.c1);
      idle(v.g2); do_edge(v.c2);
      check_column(name, v.e0, v.e1, v.e2, v.h);
   endtask

   initial begin
      tbl[0] = '{s:10,   c0:4,   c1:-3, c2:12,  g0:0, g1:0, g2:0, e0:6,  e1:13, e2:-2, h:0};
      tbl[1] = '{s:-5,   c0:-2,  c1:1,  c2:-7,  g0:0, g1:1, g2:2, e0:-3, e1:-6, e2:2,  h:1};
`ifdef VNU_SATURATE_EN
      tbl[2] = '{s:100,  c0:-20, c1:0,  c2:31,  g0:0, g1:0, g2:1, e0:31,  e1:31,  e2:31,  h:0};
      tbl[3] = '{s:-100, c0:20,  c1:0,  c2:-32, g0:1, g1:0, g2:0, e0:-31, e1:-31, e2:-31, h:1};
`else
      tbl[2] = '{s:100,  c0:-20, c1:0,  c2:31,  g0:0, g1:0, g2:1, e0:-8,  e1:-28, e2:5,   h:0};
      tbl[3] = '{s:-100, c0:20,  c1:0,  c2:-32, g0:1, g1:0, g2:0, e0:8,   e1:28,  e2:-4,  h:1};
`endif
      tbl[4] = '{s:0,    c0:1,   c1:1,  c2:1,   g0:0, g1:0, g2:0, e0:-1, e1:-1, e2:-1, h:0};

      #12 check_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;
      idle(1);

      for (int i = 0; i < 4; i++) run_vec($sformatf("tbl%0d", i), tbl[i]);

      // start and sum_valid pulsed mid-EMIT must neither restart nor re-capture
      begin_column();
      do_start();
      do_sum(10);
      do_edge(4);
      start = 1'b1; sum_valid = 1'b1; col_sum = SW'(-200);
      @(negedge clk);
      start = 1'b0; sum_valid = 1'b0;
      do_edge(-3);
      do_edge(12);
      check_column("protocol", 6, 13, -2, 0);

      // asynchronous reset in the middle of a column
      begin_column();
      do_start();
      do_sum(-20);
      do_edge(5);
      #1 chk("abort_v2c_before_reset", int'(v2c_out), ref_v2c(-20, 5));
      #2 rst_n = 1'b0;
      #1 check_zero("abort");
      @(negedge clk);
      rst_n = 1'b1;
      idle(4);
      #1 chk("abort_no_done", done_cnt, 0);
      run_vec("after_reset", tbl[4]);

      // sum_valid together with start is not a capture
      begin_column();
      start = 1'b1; sum_valid = 1'b1; col_sum = SW'(-50);
      @(negedge clk);
      start = 1'b0; sum_valid = 1'b0;
      #1 chk("same_cycle_busy", int'(busy), 1);
      idle(3);
      #1 chk("same_cycle_hard_held", int'(hard_bit), 0);
      chk("same_cycle_no_output", q.size(), 0);
      chk("same_cycle_still_waiting", int'(busy), 1);
      do_sum(7);
      do_edge(3);
      do_edge(-2);
      do_edge(20);
      check_column("same_cycle", 4, 9, -13, 0);

      for (int n = 0; n < 40; n++) begin
         vec_t v;
         v.s  = int'($urandom_range(0, 511)) - 256;
         v.c0 = int'($urandom_range(0, 63)) - 32;
         v.c1 = int'($urandom_range(0, 63)) - 32;
         v.c2 = int'($urandom_range(0, 63)) - 32;
         v.g0 = int'($urandom_range(0, 2));
         v.g1 = int'($urandom_range(0, 2));
         v.g2 = int'($urandom_range(0, 2));
         v.e0 = ref_v2c(v.s, v.c0);
         v.e1 = ref_v2c(v.s, v.c1);
         v.e2 = ref_v2c(v.s, v.c2);
         v.h  = (v.s < 0) ? 1 : 0;
         run_vec($sformatf("rand%0d", n), v);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/variable_node_update.md
# variable_node_update

Downstream neighbour of the column-sum stage in the simple LDPC belief-propagation datapath. For one column it captures the column total (channel LLR plus all incoming check-to-variable messages) and makes the hard decision. It then streams back one extrinsic variable-to-check message per edge (total minus that edge's incoming message), clipped to message width. Control follows the team's start/done convention so the column-sum controller can chain directly into it.

## Interface
- DW, 6: signed message (LLR) width, two's complement
- SW, 9: signed column-sum width; must be ≥ DW
- COL_WT, 3: edges per column; must be ≥ 1
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  pulse; begins a column when idle
- col_sum  in  SW  signed column total; sampled when sum_valid
- sum_valid  in  1  col_sum qualifier
- c2v_in  in  DW  signed incoming check-to-variable message for the current edge
- c2v_valid  in  1  c2v_in qualifier
- v2c_out  out  DW  signed extrinsic message, registered
- v2c_valid  out  1  v2c_out qualifier, one cycle per message
- hard_bit  out  1  hard decision of the captured column (1 when col_sum < 0)
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse at column completion

## Operation
- States: IDLE, WAIT_SUM, EMIT, DONE.
- IDLE: start=1 → WAIT_SUM. sum_valid in the same cycle as start is ignored.
- WAIT_SUM: sum_valid=1 → capture col_sum into sum_reg, set hard_bit = col_sum[SW-1], clear edge counter → EMIT.
- EMIT: each cycle with c2v_valid=1 computes diff = sum_reg − c2v_in at SW+1 bits, sign-extends both operands, and registers sat(diff) into v2c_out. The edge counter increments. The accept that brings the count to COL_WT moves the FSM to DONE. Cycles with c2v_valid=0 are gaps: no output and no count.
- DONE: done=1 for exactly one cycle → IDLE.
- start is ignored while busy. sum_valid outside WAIT_SUM is ignored. c2v_valid outside EMIT is ignored.
- hard_bit holds its value until the next capture.
- Saturation is symmetric to ±(2^(DW−1)−1); the most-negative code is never emitted.

## Timing
- Reset values (rst_n low, asynchronous): state=IDLE, v2c_out=0, v2c_valid=0, hard_bit=0, busy=0, done=0, counter=0, sum_reg=0.
- Reset asserted mid-column aborts immediately. No done pulse is produced, and the next column needs a fresh start.
- Latency: v2c_out and v2c_valid appear one cycle after the c2v_in accept.
- The last message's v2c_valid and done assert in the same cycle (accept cycle + 1). busy drops the cycle after that.
- Minimum column duration is COL_WT+3 cycles from the start sample to the done pulse.
- busy asserts the cycle after start is sampled.

## Configuration
- VNU_SATURATE_EN defined: v2c_out = diff clipped to ±(2^(DW−1)−1).
- VNU_SATURATE_EN undefined: v2c_out = diff[DW−1:0]. The result wraps with no clipping, which gives smaller logic for width-safe configurations.
- hard_bit and the FSM are unaffected by the macro.

## Structure
- Shared package ldpc_bp_pkg holds:
  - the DW/SW defaults;
  - the state encoding (IDLE=0, WAIT_SUM=1, EMIT=2, DONE=3);
  - the LLR_MAX/LLR_MIN saturation constants.
- Sub-module llr_saturate is combinational, SW+1 bits in and DW bits out. The macro is evaluated inside it. The top level holds only the FSM, counter and registers.

## Test plan
Defaults apply (DW=6, SW=9, COL_WT=3) unless stated.
- Nominal: col_sum=10, c2v = 4, −3, 12 on consecutive cycles → v2c = 6, 13, −2; hard_bit=0; done coincides with the third v2c_valid.
- Negative column plus gaps: col_sum=−5, c2v = −2, (idle), 1, (idle, idle), −7 → v2c = −3, −6, 2 with matching gaps; hard_bit=1; exactly one done pulse.
- Saturation:
  - With VNU_SATURATE_EN, col_sum=100, c2v=−20 → v2c=31, and col_sum=−100, c2v=20 → v2c=−31.
  - Without the macro, the same inputs give −8 and 8.
- Protocol: start pulsed during EMIT and sum_valid pulsed during EMIT → no state change and no re-capture; column completes normally.
- Reset mid-EMIT after one message: drop rst_n asynchronously → all outputs 0 in the same cycle and state IDLE. A new column afterwards (col_sum=0, c2v = 1, 1, 1 → v2c = −1, −1, −1) completes correctly.
- start and sum_valid in the same IDLE cycle → sum not captured; FSM waits in WAIT_SUM for a later sum_valid.
